zet_wb_arbiter: RTL

- Two-master to one-slave Wishbone arbiter downstream of the Zet processor top.
- Merges the instruction-fetch port (wbf_*) and execution port (wb_*) onto a single system bus.
- Grant is held for a whole bus cycle, with exec-priority arbitration bounded by a fetch-fairness counter.
- A watchdog terminates cycles the slave never acknowledges.

---
 rtl/zet_wb_pkg.sv | 20 ++
 rtl/zet_wb_watchdog.sv | 39 +++
 rtl/zet_wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/zet_wb_pkg.sv
// Shared definitions for the Zet Wishbone arbiter slice.
//   state_t         : arbiter state encoding (registered, 2 bits)
//   TMO_FILL        : read data returned to a master whose cycle was
//                     terminated by the watchdog
//   DEF_EXEC_BURST  : default max consecutive exec grants while fetch waits
//   DEF_TIMEOUT     : default watchdog limit in cycles (0 disables)
package zet_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TERM  = 2'd3
  } state_t;

  localparam logic [15:0] TMO_FILL       = 16'hFFFF;
  localparam int          DEF_EXEC_BURST = 4;
  localparam int          DEF_TIMEOUT    = 64;

endpackage

// File: rtl/zet_wb_watchdog.sv
// Bus watchdog: counts cycles where the strobe is up without an
// acknowledge and raises fire once the count has reached TIMEOUT.
//   clk, rst : clock, asynchronous active-high reset
//   stb      : downstream strobe currently presented to the slave
//   ack      : slave acknowledge (clears the count, suppresses fire)
//   clr      : arbiter state is changing this cycle (clears the count)
//   fire     : combinational, next arbiter state must be TERM
module zet_wb_watchdog
  import zet_wb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic fire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] wdt;

  // Count holds at LIMIT so it can never wrap past the compare value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt <= 8'd0;
    end else if (ack || clr) begin
      wdt <= 8'd0;
    end else if (stb && (wdt != LIMIT)) begin
      wdt <= wdt + 8'd1;
    end
  end

  // A genuine ack in the limit cycle wins over the timeout.
  assign fire = (TIMEOUT != 0) && stb && !ack && (wdt == LIMIT);

endmodule

// File: rtl/zet_wb_arbiter.sv
// Two-master (instruction fetch, execution) to one-slave Wishbone arbiter.
// Exec has priority, bounded by a fairness counter that forces a fetch
// grant after EXEC_BURST consecutive exec grants while fetch is waiting.
// A watchdog terminates cycles the slave never acknowledges.
//   wbf_* : fetch master port (read only)
//   wbe_* : exec master port (read/write, io/mem tag)
//   wbm_* : slave-side bus
//   tmo_o : sticky flag, set when the watchdog terminated a cycle
module zet_wb_arbiter
  import zet_wb_pkg::*;
#(
  parameter int EXEC_BURST = DEF_EXEC_BURST,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] wbf_dat_o,
  input  logic [19:1] wbf_adr_i,
  input  logic [1:0]  wbf_sel_i,
  input  logic        wbf_cyc_i,
  input  logic        wbf_stb_i,
  output logic        wbf_ack_o,
  input  logic [15:0] wbe_dat_i,
  output logic [15:0] wbe_dat_o,
  input  logic [19:1] wbe_adr_i,
  input  logic        wbe_we_i,
  input  logic        wbe_tga_i,
  input  logic [1:0]  wbe_sel_i,
  input  logic        wbe_cyc_i,
  input  logic        wbe_stb_i,
  output logic        wbe_ack_o,
  input  logic [15:0] wbm_dat_i,
  output logic [15:0] wbm_dat_o,
  output logic [19:1] wbm_adr_o,
  output logic        wbm_we_o,
  output logic        wbm_tga_o,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        tmo_o
);

  localparam logic [3:0] BURST_MAX = 4'(EXEC_BURST);

  state_t     state;
  state_t     arb_st;
  state_t     next_st;
  logic [3:0] burst_cnt;
  logic       term_exec;
  logic       wdt_fire;

  zet_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk  (clk_i),
    .rst  (rst_i),
    .stb  (wbm_stb_o),
    .ack  (wbm_ack_i),
    .clr  (next_st != state),
    .fire (wdt_fire)
  );

  // Arbitration result and next state. Re-arbitration happens from IDLE,
  // after TERM, or when the current owner has released cyc; holding cyc
  // (even with stb low) keeps the grant.
  always_comb begin
    arb_st = ST_IDLE;
    if (wbe_cyc_i && wbf_cyc_i) begin
      arb_st = (burst_cnt == BURST_MAX) ? ST_FETCH : ST_EXEC;
    end else if (wbe_cyc_i) begin
      arb_st = ST_EXEC;
    end else if (wbf_cyc_i) begin
      arb_st = ST_FETCH;
    end

    next_st = state;
    if (wdt_fire) begin
      next_st = ST_TERM;
    end else begin
      case (state)
        ST_FETCH: if (!wbf_cyc_i) next_st = arb_st;
        ST_EXEC:  if (!wbe_cyc_i) next_st = arb_st;
        default:  next_st = arb_st;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      burst_cnt <= 4'd0;
      term_exec <= 1'b0;
      tmo_o     <= 1'b0;
    end else begin
      state <= next_st;
      if (wdt_fire) begin
        term_exec <= (state == ST_EXEC);
        tmo_o     <= 1'b1;
      end
      // Fairness: count fresh exec grants only while fetch is waiting.
      if (!wbf_cyc_i) begin
        burst_cnt <= 4'd0;
      end else if ((next_st == ST_FETCH) && (state != ST_FETCH)) begin
        burst_cnt <= 4'd0;
      end else if ((next_st == ST_EXEC) && (state != ST_EXEC) &&
                   (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  // Owner-steered pass-through; IDLE and TERM present an idle bus.
  always_comb begin
    wbm_dat_o = 16'd0;
    wbm_adr_o = 19'd0;
    wbm_we_o  = 1'b0;
    wbm_tga_o = 1'b0;
    wbm_sel_o = 2'd0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbf_ack_o = 1'b0;
    wbe_ack_o = 1'b0;
    wbf_dat_o = wbm_dat_i;
    wbe_dat_o = wbm_dat_i;
    case (state)
      ST_FETCH: begin
        wbm_adr_o = wbf_adr_i;
        wbm_sel_o = wbf_sel_i;
        wbm_cyc_o = wbf_cyc_i;
        wbm_stb_o = wbf_stb_i;
        wbf_ack_o = wbm_ack_i;
      end
      ST_EXEC: begin
        wbm_dat_o = wbe_dat_i;
        wbm_adr_o = wbe_adr_i;
        wbm_we_o  = wbe_we_i;
        wbm_tga_o = wbe_tga_i;
        wbm_sel_o = wbe_sel_i;
        wbm_cyc_o = wbe_cyc_i;
        wbm_stb_o = wbe_stb_i;
        wbe_ack_o = wbm_ack_i;
      end
      ST_TERM: begin
        if (term_exec) begin
          wbe_ack_o = 1'b1;
          wbe_dat_o = TMO_FILL;
        end else begin
          wbf_ack_o = 1'b1;
          wbf_dat_o = TMO_FILL;
        end
      end
      default: ;
    endcase
  end

endmodule
